// File: rtl/serial_adder_16bit.sv
// serial_adder_16bit: nibble-serial adder built around one shared 4-bit adder.
// Operands are captured on Start, summed four bits per cycle, and the result,
// carry-out and signed-overflow flag are published together on entering DONE.
// Optional feature: define SERIAL_SUB_EN to add the Sub port (A-B via ~B + 1).

// Shared 4-bit full adder slice
module adder_4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);
   assign {Cout, Sum} = 5'(A) + 5'(B) + 5'(Cin);
endmodule

module serial_adder_16bit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_SUB_EN
   input  logic             Sub,
`endif
   output logic             Ready,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned NIB   = WIDTH / 4;
   localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-5:0] r_acc;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_nib_sum;
   logic             w_nib_cout;
   logic             w_last;
   logic             w_ovf;

   // Single adder instance, time-shared across all nibbles
   adder_4bit u_adder (
      .A    (r_a[3:0]),
      .B    (r_b[3:0]),
      .Cin  (r_carry),
      .Sum  (w_nib_sum),
      .Cout (w_nib_cout)
   );

   assign w_last = (r_cnt == CNT_W'(NIB - 1));
   // Carry into the MSB is recovered from the MSB's own sum bit and operands
   assign w_ovf  = r_a[3] ^ r_b[3] ^ w_nib_sum[3] ^ w_nib_cout;

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (Start)  w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Status flags registered from the upcoming state
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (w_next_state == S_IDLE);
         r_done  <= (w_next_state == S_DONE);
      end
   end

   // Operand capture, nibble-serial accumulation and result publication
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (Start) begin
            r_a   <= A;
            r_cnt <= '0;
            r_acc <= '0;
`ifdef SERIAL_SUB_EN
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
`else
            r_b     <= B;
            r_carry <= Cin;
`endif
         end
      end else if (r_state == S_RUN) begin
         r_a     <= {4'b0000, r_a[WIDTH-1:4]};
         r_b     <= {4'b0000, r_b[WIDTH-1:4]};
         r_carry <= w_nib_cout;
         r_cnt   <= r_cnt + CNT_W'(1);
         r_acc   <= {w_nib_sum, r_acc[WIDTH-5:4]};
         if (w_last) begin
            r_sum  <= {w_nib_sum, r_acc};
            r_cout <= w_nib_cout;
            r_ovf  <= w_ovf;
         end
      end
   end

   assign Ready = r_ready;
   assign Done  = r_done;
   assign Sum   = r_sum;
   assign Cout  = r_cout;
   assign Ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Bench for serial_adder_16bit: directed vector table, hand-written corner
// sequences (disturbance during RUN, mid-run reset, back-to-back Start) and
// randomized operations checked against a plain-arithmetic reference model.
module tb_serial_adder_16bit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
`ifdef SERIAL_SUB_EN
   logic        Sub;
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif
   logic        Ready;
   logic        Done;
   logic [15:0] Sum;
   logic        Cout;
   logic        Ovf;

   int total = 0;
   int bad   = 0;

   serial_adder_16bit #(.WIDTH(16)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
`ifdef SERIAL_SUB_EN
      .Sub   (Sub),
`endif
      .Ready (Ready),
      .Done  (Done),
      .Sum   (Sum),
      .Cout  (Cout),
      .Ovf   (Ovf)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic, overflow from operand/result signs
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output logic [15:0] s, output logic co,
                        output logic ov);
      logic [15:0] bb;
      logic        ci;
      logic [16:0] r;
      bb = (sub && SUB_EN) ? ~b : b;
      ci = (sub && SUB_EN) ? 1'b1 : cin;
      r  = 17'(a) + 17'(bb) + 17'(ci);
      s  = r[15:0];
      co = r[16];
      ov = (a[15] == bb[15]) && (s[15] != a[15]);
   endtask

   // One operation; optionally disturbs inputs during RUN. Checks latency,
   // held outputs during RUN and single Done pulse.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input bit disturb, input string tag,
                         output logic [15:0] s, output logic co, output logic ov);
      logic [15:0] prev_sum;
      int          lat;
      bit          seen;
      @(negedge Clk);
      A = a; B = b; Cin = cin; Start = 1'b1;
`ifdef SERIAL_SUB_EN
      Sub = sub;
`endif
      @(posedge Clk); #1;
      Start = 1'b0;
      prev_sum = Sum;
      chk({tag, " ready_low"}, 32'(Ready), 32'd0);
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge Clk); #1;
         if (disturb && i == 1) begin A = 16'h0000; B = ~b; Cin = ~cin; Start = 1'b1; end
         if (disturb && i == 2) Start = 1'b0;
         if (Done) begin seen = 1'b1; lat = i; break; end
         chk({tag, " sum_held"}, 32'(Sum), 32'(prev_sum));
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'd4);
      s = Sum; co = Cout; ov = Ovf;
      @(posedge Clk); #1;
      chk({tag, " done_single"}, 32'(Done), 32'd0);
      chk({tag, " ready_back"}, 32'(Ready), 32'd1);
      if (disturb) begin
         for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            chk({tag, " no_extra_done"}, 32'(Done), 32'd0);
         end
      end
   endtask

   vec_t        vt[$];
   logic [15:0] s, es;
   logic        co, ov, eco, eov;

   initial begin
      Rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_SUB_EN
      Sub = 1'b0;
`endif
      #1;
      chk("rst_ready", 32'(Ready), 32'd1);
      chk("rst_done",  32'(Done),  32'd0);
      chk("rst_sum",   32'(Sum),   32'd0);
      chk("rst_flags", 32'({Cout, Ovf}), 32'd0);
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;

      vt.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
      vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
      vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
      vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
      vt.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
      vt.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
`ifdef SERIAL_SUB_EN
      vt.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
      vt.push_back('{16'h0009, 16'h0004, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0});
      vt.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif
      foreach (vt[i]) begin
         run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b0, "vec", s, co, ov);
         chk("vec_sum",  32'(s),  32'(vt[i].s));
         chk("vec_cout", 32'(co), 32'(vt[i].co));
         chk("vec_ovf",  32'(ov), 32'(vt[i].ov));
      end

      // Inputs disturbed during RUN must not affect the captured operation
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, "dist", s, co, ov);
      chk("dist_sum",  32'(s),  32'hFFFF);
      chk("dist_cout", 32'(co), 32'd1);

      // Leave a nonzero result, then abort an operation with reset
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "pre", s, co, ov);
      chk("pre_sum", 32'(s), 32'h8000);
      @(negedge Clk);
      A = 16'h1111; B = 16'h2222; Cin = 1'b0; Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      Rst = 1'b1;
      #1;
      chk("mrst_sum",   32'(Sum),   32'd0);
      chk("mrst_flags", 32'({Cout, Ovf}), 32'd0);
      chk("mrst_ready", 32'(Ready), 32'd1);
      chk("mrst_done",  32'(Done),  32'd0);
      @(posedge Clk); #1 Rst = 1'b0;
      begin
         int dones = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
         end
         chk("mrst_no_done", 32'(dones), 32'd0);
      end
      run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, "post", s, co, ov);
      chk("post_sum", 32'(s), 32'h0005);

      // Start held high: back-to-back operations every six cycles
      begin
         int t_first = -1, t_second = -1, wait_cnt = 0;
         @(negedge Clk);
         A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; Start = 1'b1;
         for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (Done) begin
               if (t_first < 0) t_first = i;
               else if (t_second < 0) t_second = i;
               chk("b2b_sum", 32'(Sum), 32'h1000);
            end
         end
         Start = 1'b0;
         chk("b2b_period", 32'(t_second - t_first), 32'd6);
         while (!Ready && wait_cnt < 20) begin @(posedge Clk); #1; wait_cnt++; end
         chk("b2b_drain", 32'(Ready), 32'd1);
      end

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra, rb;
         logic        rc, rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rc, rs, es, eco, eov);
         run_op(ra, rb, rc, rs, 1'b0, "rnd", s, co, ov);
         chk("rnd_sum",  32'(s),  32'(es));
         chk("rnd_cout", 32'(co), 32'(eco));
         chk("rnd_ovf",  32'(ov), 32'(eov));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_16bit.md
SERIAL_ADDER_16BIT -- requirements
Module: serial_adder_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (multiple of 4, minimum 8).
REQ-002 SHALL have port Clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  first operand; captured on the accepted Start.
REQ-006 SHALL have port B  input  WIDTH  second operand; captured on the accepted Start.
REQ-007 SHALL have port Cin  input  1  carry-in; captured on the accepted Start.
REQ-008 SHALL have port Sub  input  1  subtract select; present only with SERIAL_SUB_EN.
REQ-009 SHALL have port Ready  output  1  high while in IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle pulse marking a new result.
REQ-011 SHALL have port Sum  output  WIDTH  registered result.
REQ-012 SHALL have port Cout  output  1  registered carry-out of the MSB nibble.
REQ-013 SHALL have port Ovf  output  1  registered signed-overflow flag.

Function
REQ-014 SHALL contain exactly one instance of the team's 4-bit full adder (A, B, Cin, Sum, Cout), time-shared across all nibbles.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: Start=1 at a rising edge captures A, B and Cin into internal shift registers, clears the nibble counter, and moves to RUN.
REQ-017 RUN: each cycle adds the operand registers' low nibbles plus the carry register, shifts the 4-bit result into the top of the internal result register, stores the adder Cout in the carry register, shifts both operand registers right by 4, and increments the counter.
REQ-018 RUN SHALL move to DONE on the edge completing nibble WIDTH/4 (four nibbles for WIDTH=16).
REQ-019 On entering DONE, Sum, Cout and Ovf SHALL load together; Ovf = carry into MSB XOR carry out of MSB.
REQ-020 DONE: Done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-021 Latency: Start accepted at edge t0 -> Done high in the cycle following edge t0+WIDTH/4; a new Start is accepted no earlier than edge t0+WIDTH/4+1.
REQ-022 Start, A, B, Cin (and Sub) SHALL be ignored in RUN and DONE; operand changes during RUN SHALL NOT affect the result.
REQ-023 Sum, Cout and Ovf SHALL hold the previous result throughout RUN and until the next DONE; no partial values are visible.
REQ-024 Start held high continuously SHALL produce back-to-back operations of WIDTH/4+2 cycles each.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; carry beyond the MSB appears only on Cout.

Reset
REQ-026 Rst=1 SHALL immediately force IDLE, Ready=1, Done=0, Sum=0, Cout=0, Ovf=0, and clear the counter, carry and shift registers, without waiting for a clock edge.
REQ-027 Rst asserted during RUN or DONE SHALL abort the operation with no Done pulse; the first Start after Rst deasserts SHALL begin a fresh operation.

Configuration
REQ-028 Macro SERIAL_SUB_EN: when defined, port Sub exists; Sub=1 at Start captures ~B and forces the initial carry to 1 (Cin ignored), giving A-B with Cout=1 meaning no borrow.
REQ-029 Without SERIAL_SUB_EN: no Sub port; the block performs A+B+Cin only; area excludes the inversion logic.

Verification
REQ-030 A=0x1234, B=0x4321, Cin=0, Start pulse -> Done in cycle after edge t0+4; Sum=0x5555, Cout=0, Ovf=0.
REQ-031 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; then A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-032 A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1; Start pulsed and A changed to 0x0000 during RUN -> no effect, single Done.
REQ-033 Rst asserted mid-RUN after edge t0+2 -> all outputs 0 immediately, Ready=1, no Done; next Start with A=0x0002, B=0x0003 -> Sum=0x0005.
REQ-034 With SERIAL_SUB_EN: A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0; A=0x0009, B=0x0004, Sub=1 -> Sum=0x0005, Cout=1.
